// File: rtl/calc_sequencer.sv
// Command sequencer for 16-bit add/sub/mul and a multi-cycle restoring div/mod,
// with a valid/ready handshake on both the command and result sides.
module calc_sequencer #(
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  command,
    input  logic [15:0] inputP,
    input  logic [15:0] inputQ,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic        flag_carry,
    output logic        flag_overflow,
    output logic        flag_div_zero,
    output logic        flag_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    localparam int         DIV_CYCLES = 16 / DIV_BITS_PER_CYCLE;
    localparam logic [3:0] LAST_CNT   = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] p_q, p_d;
    logic [15:0] q_q, q_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        dz_q, dz_d;
    logic        ill_q, ill_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dq_q, dq_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [16:0] add_full;
    logic [16:0] sub_full;
    logic [31:0] mul_full;

    assign add_full = {1'b0, p_q} + {1'b0, q_q};
    assign sub_full = {1'b0, p_q} + {1'b0, ~q_q} + 17'd1;
    assign mul_full = 32'(p_q) * 32'(q_q);

    // dq holds the not-yet-consumed dividend bits in the top and the
    // quotient bits shifted in at the bottom; after 16 steps it is the quotient.
    logic [15:0] rem_chain [DIV_BITS_PER_CYCLE+1];
    logic [15:0] dq_chain  [DIV_BITS_PER_CYCLE+1];

    assign rem_chain[0] = rem_q;
    assign dq_chain[0]  = dq_q;

    for (genvar gi = 0; gi < DIV_BITS_PER_CYCLE; gi++) begin : g_div_step
        logic [16:0] trial;
        logic        fits;
        assign trial = {rem_chain[gi], dq_chain[gi][15]};
        assign fits  = (trial >= {1'b0, q_q});
        // Remainder stays below the divisor, so the 16-bit modular difference is exact.
        assign rem_chain[gi+1] = fits ? (trial[15:0] - q_q) : trial[15:0];
        assign dq_chain[gi+1]  = {dq_chain[gi][14:0], fits};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        p_d      = p_q;
        q_d      = q_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        ill_d    = ill_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = command;
                    p_d     = inputP;
                    q_d     = inputQ;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d  = DONE;
                result_d = '0;
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
                dz_d     = 1'b0;
                ill_d    = 1'b0;
                rem_d    = '0;
                dq_d     = p_q;
                cnt_d    = '0;
                case (op_q)
                    4'd0: begin
                        result_d = {16'b0, add_full[15:0]};
                        carry_d  = add_full[16];
                        ovf_d    = (p_q[15] == q_q[15]) && (add_full[15] != p_q[15]);
                    end
                    4'd1: begin
                        result_d = {16'b0, sub_full[15:0]};
                        carry_d  = ~sub_full[16];
                        ovf_d    = (p_q[15] != q_q[15]) && (sub_full[15] != p_q[15]);
                    end
                    4'd2: result_d = mul_full;
                    4'd3, 4'd4: begin
                        if (q_q == 16'd0) begin
                            dz_d = 1'b1;
                        end else begin
                            state_d = DIV;
                        end
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            DIV: begin
                rem_d = rem_chain[DIV_BITS_PER_CYCLE];
                dq_d  = dq_chain[DIV_BITS_PER_CYCLE];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    result_d = (op_q == 4'd3) ? {16'b0, dq_chain[DIV_BITS_PER_CYCLE]}
                                              : {16'b0, rem_chain[DIV_BITS_PER_CYCLE]};
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            p_q      <= '0;
            q_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
            rem_q    <= '0;
            dq_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            p_q      <= p_d;
            q_q      <= q_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign res_valid     = (state_q == DONE);
    assign result        = result_q;
    assign flag_carry    = carry_q;
    assign flag_overflow = ovf_q;
    assign flag_div_zero = dz_q;
    assign flag_illegal  = ill_q;

endmodule
